board_engine: RTL and testbench
===============================

// Module: board_engine
// PURPOSE
//  Responder for the playfield query/move interface. Holds the Sokoban-style board state and
//  answers the renderer's per-pixel cell requests (req_x/req_y -> chunk_type, 1-cycle latency).
//  Applies one-cycle move commands from the switch edge-detector in TOP, and reloads the level on RESET.
//  Sits between the switch edge-detector and the RENDER block, clocked by the 100MHz clk.
// PARAMETERS
//  GRID_W      10        board columns (480px / 48px cells)
//  GRID_H      10        board rows
//  CELL_W      4         cell code width (matches chunk_type)
//  LEVEL_INIT  400'h0    GRID_W*GRID_H*CELL_W initial board; cell (x,y) at bits [(y*GRID_W+x)*4 +: 4]
//  START_X/Y   1 / 1     initial player coordinates (must hold a PLAYER* code in LEVEL_INIT)
// PORTS
//  clk         in   1   system clock
//  rstn        in   1   synchronous reset, active-low
//  is_center   in   1   pixel lies inside the 480px playfield
//  req_x       in   4   requested cell column
//  req_y       in   4   requested cell row
//  move        in   3   move command, NONE=0 RIGHT=1 LEFT=2 DOWN=3 UP=4 RESET=5 (UNDO=6 optional)
//  chunk_type  out  4   registered cell code for the previous cycle's request
//  busy        out  1   engine loading/committing; incoming moves are dropped
//  win         out  1   every box sits on a target
//  steps       out  10  successful player moves since load, saturates at 1023
// BEHAVIOUR
//  Cell codes: EMPTY=0 WALL=1 BOX=2 TARGET=3 BOX_T=4 PLAYER=5 PLAYER_T=6 OUTSIDE=15.
//  Read port: each cycle, chunk_type <= OUTSIDE if !is_center or req_x>=GRID_W or req_y>=GRID_H,
//   else grid[req_y][req_x]. The read port is independent of the FSM; it is valid during LOAD and
//   shows partially loaded cells.
//  Reset (rstn=0 at a clk edge): chunk_type=0, win=0, steps=0, busy=1, state=LOAD, load_idx=0.
//   Reset mid-move or mid-load aborts and restarts LOAD.
//  FSM: LOAD -> IDLE -> CHECK -> COMMIT -> IDLE.
//  LOAD: writes one cell per cycle from LEVEL_INIT (idx 0..GRID_W*GRID_H-1). Sets px/py=START_X/Y
//   and steps=0. Moves to IDLE after the last cell (100 cycles). busy=1 throughout.
//  IDLE: busy=0. move=RESET -> LOAD. A direction is accepted only if win=0. NONE is ignored.
//   Accepting a direction latches it; next state CHECK.
//  CHECK: n1=player+dir, n2=player+2*dir. Off-grid coordinates read as WALL (no wrap; 4-bit underflow
//   at x=0 is caught). Decide:
//   - n1 in {EMPTY,TARGET}: walk.
//   - n1 in {BOX,BOX_T} and n2 in {EMPTY,TARGET}: push.
//   - anything else: blocked; go to IDLE with no state change.
//  COMMIT: one cycle, all writes simultaneous.
//   - Old player cell -> TARGET if it was PLAYER_T, else EMPTY.
//   - n1 -> PLAYER_T if its underlying cell is a target, else PLAYER.
//   - On push, n2 -> BOX_T if TARGET, else BOX.
//   - px/py update; steps+1 (saturating).
//   - win recomputed next cycle as (no cell == BOX); also recomputed at end of LOAD.
//  busy=1 in CHECK and COMMIT. Moves arriving while busy=1 (incl. RESET) are dropped, not queued.
//  Move-to-visible latency: accept at cycle N, grid updated at edge N+2, chunk_type reflects it at N+3.
// CONFIGURATION
//  BOARD_UNDO_EN defined: move=6 (UNDO) accepted in IDLE when an undo record is valid.
//   - Record is saved on every COMMIT: old player cell, n1, n2 codes + coords, px/py.
//   - UNDO restores them in one cycle, decrements steps (floor 0), recomputes win, and invalidates
//     the record (single level). LOAD invalidates the record.
//  BOARD_UNDO_EN undefined: code 6 is treated as NONE; no record storage is built.
// STRUCTURE
//  board_pkg (PARAMS.v defines): cell codes, move codes incl. UNDO, GRID_W/H, CELL_W, OUTSIDE.
//  Sub-module board_level_rom: idx -> 4-bit initial cell from LEVEL_INIT (combinational).
//  Grid lives in flops (GRID_W*GRID_H*4 bits); a single write port per cell; no BRAM.
// TESTING
//  1 Reset, then run 100 cycles: busy falls at cycle 100; req(1,1) returns PLAYER; is_center=0 -> 15.
//  2 Player (1,1), EMPTY at (2,1); move=RIGHT pulse -> after 3 cycles (1,1)=EMPTY, (2,1)=PLAYER, steps=1.
//  3 BOX (2,1), TARGET (3,1), RIGHT -> (3,1)=BOX_T, (2,1)=PLAYER; win=1 if last box; next RIGHT ignored.
//  4 Player (0,y), LEFT -> blocked: grid and steps unchanged. Box against a WALL, push -> unchanged.
//  5 RIGHT then LEFT on consecutive cycles -> LEFT dropped (busy). RESET mid-game -> LEVEL_INIT restored, steps=0.
//  6 BOARD_UNDO_EN: push a box, UNDO -> all 3 cells and steps back; second UNDO -> no change.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, cell/move codes, FSM states and cell index helper.
//  Exports: GRID_W, GRID_H, CELL_W, CELLS, IDX_W, cell_e (incl. C_OUTSIDE), move_e (incl. M_UNDO),
//  state_e, idx_of(x, y).
package board_pkg;

    localparam int GRID_W = 10;
    localparam int GRID_H = 10;
    localparam int CELL_W = 4;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int IDX_W  = $clog2(CELLS);

    typedef enum logic [CELL_W-1:0] {
        C_EMPTY    = 4'd0,
        C_WALL     = 4'd1,
        C_BOX      = 4'd2,
        C_TARGET   = 4'd3,
        C_BOX_T    = 4'd4,
        C_PLAYER   = 4'd5,
        C_PLAYER_T = 4'd6,
        C_OUTSIDE  = 4'd15
    } cell_e;

    typedef enum logic [2:0] {
        M_NONE  = 3'd0,
        M_RIGHT = 3'd1,
        M_LEFT  = 3'd2,
        M_DOWN  = 3'd3,
        M_UP    = 3'd4,
        M_RESET = 3'd5,
        M_UNDO  = 3'd6
    } move_e;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_CHECK,
        S_COMMIT
    } state_e;

    // Row-major flat cell index.
    function automatic logic [IDX_W-1:0] idx_of(input logic [3:0] x, input logic [3:0] y);
        return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
    endfunction

endpackage

// File: rtl/board_if.sv
// board_if: playfield query/move bundle between the requester and the board engine.
//  master drives: is_center, req_x, req_y, move
//  slave drives : chunk_type, busy, win, steps
interface board_if;

    logic       is_center;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic [2:0] move;
    logic [3:0] chunk_type;
    logic       busy;
    logic       win;
    logic [9:0] steps;

    modport master (
        output is_center, req_x, req_y, move,
        input  chunk_type, busy, win, steps
    );

    modport slave (
        input  is_center, req_x, req_y, move,
        output chunk_type, busy, win, steps
    );

endinterface

// File: rtl/board_level_rom.sv
// board_level_rom: combinational lookup of the initial cell code for a flat cell index.
//  idx_i  in  IDX_W   flat cell index (y*GRID_W+x)
//  cell_o out CELL_W  initial cell code taken from LEVEL_INIT
module board_level_rom
    import board_pkg::*;
#(
    parameter logic [CELLS*CELL_W-1:0] LEVEL_INIT = '0
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [CELL_W-1:0] cell_o
);

    assign cell_o = LEVEL_INIT[idx_i*CELL_W +: CELL_W];

endmodule

// File: rtl/board_engine.sv
// board_engine: Sokoban board state holder, per-pixel cell read port and move engine.
//  clk   in  system clock
//  rstn  in  synchronous reset, active-low
//  bus   board_if.slave: is_center/req_x/req_y/move in; chunk_type/busy/win/steps out
//  Optional single-level undo (move code 6) is built when BOARD_UNDO_EN is defined.
module board_engine
    import board_pkg::*;
#(
    parameter logic [CELLS*CELL_W-1:0] LEVEL_INIT = '0,
    parameter logic [3:0]              START_X    = 4'd1,
    parameter logic [3:0]              START_Y    = 4'd1
) (
    input logic   clk,
    input logic   rstn,
    board_if.slave bus
);

    state_e            state_q, state_d;
    logic [CELL_W-1:0] grid_q [CELLS];
    logic [CELL_W-1:0] grid_d [CELLS];
    logic [IDX_W-1:0]  load_idx_q, load_idx_d;
    logic [3:0]        px_q, px_d, py_q, py_d;
    logic [2:0]        dir_q, dir_d;
    logic              push_q, push_d;
    logic [9:0]        steps_q, steps_d;
    logic              win_q, win_d, recalc_q, recalc_d;
    logic [CELL_W-1:0] chunk_q, chunk_d;

    logic [CELL_W-1:0] rom_cell;
    logic [4:0]        dx, dy, n1x, n1y, n2x, n2y;
    logic              n1_off, n2_off;
    logic [IDX_W-1:0]  p_idx, n1_idx, n2_idx, rd_idx;
    logic [CELL_W-1:0] p_c, n1_c, n2_c;
    logic              walk, push_ok, is_dir, last_load, no_box;

    board_level_rom #(.LEVEL_INIT(LEVEL_INIT)) u_rom (
        .idx_i (load_idx_q),
        .cell_o(rom_cell)
    );

    // Neighbour geometry uses 5-bit coordinates so a step left/up from 0 becomes
    // a large value that fails the range test instead of wrapping onto the grid.
    always_comb begin
        dx      = (dir_q == M_RIGHT) ? 5'd1 : (dir_q == M_LEFT) ? 5'h1f : 5'd0;
        dy      = (dir_q == M_DOWN) ? 5'd1 : (dir_q == M_UP) ? 5'h1f : 5'd0;
        n1x     = {1'b0, px_q} + dx;
        n1y     = {1'b0, py_q} + dy;
        n2x     = n1x + dx;
        n2y     = n1y + dy;
        n1_off  = (n1x >= 5'(GRID_W)) || (n1y >= 5'(GRID_H));
        n2_off  = (n2x >= 5'(GRID_W)) || (n2y >= 5'(GRID_H));
        p_idx   = idx_of(px_q, py_q);
        n1_idx  = idx_of(n1x[3:0], n1y[3:0]);
        n2_idx  = idx_of(n2x[3:0], n2y[3:0]);
        p_c     = grid_q[p_idx];
        n1_c    = n1_off ? C_WALL : grid_q[n1_idx];
        n2_c    = n2_off ? C_WALL : grid_q[n2_idx];
        walk    = (n1_c == C_EMPTY) || (n1_c == C_TARGET);
        push_ok = ((n1_c == C_BOX) || (n1_c == C_BOX_T)) && ((n2_c == C_EMPTY) || (n2_c == C_TARGET));
    end

    always_comb begin
        is_dir    = (bus.move >= M_RIGHT) && (bus.move <= M_UP);
        last_load = (load_idx_q == IDX_W'(CELLS - 1));
        rd_idx    = idx_of(bus.req_x, bus.req_y);
        no_box    = 1'b1;
        for (int i = 0; i < CELLS; i++) no_box = no_box & (grid_q[i] != C_BOX);
    end

`ifdef BOARD_UNDO_EN
    // Single-level undo record: snapshot of the three touched cells before each commit.
    logic              undo_fire, u_valid_q, u_valid_d, u_push_q;
    logic [3:0]        u_px_q, u_py_q;
    logic [IDX_W-1:0]  u_n1_idx_q, u_n2_idx_q;
    logic [CELL_W-1:0] u_pc_q, u_n1c_q, u_n2c_q;

    assign undo_fire = (state_q == S_IDLE) && (bus.move == M_UNDO) && u_valid_q;
    assign u_valid_d = (state_q == S_COMMIT) ? 1'b1 : ((state_q == S_LOAD) || undo_fire) ? 1'b0 : u_valid_q;

    always_ff @(posedge clk) begin
        u_valid_q <= rstn ? u_valid_d : 1'b0;
        if (state_q == S_COMMIT) begin
            u_push_q   <= push_q;
            u_px_q     <= px_q;
            u_py_q     <= py_q;
            u_n1_idx_q <= n1_idx;
            u_n2_idx_q <= n2_idx;
            u_pc_q     <= p_c;
            u_n1c_q    <= n1_c;
            u_n2c_q    <= n2_c;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        state_q <= rstn ? state_d : S_LOAD;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = last_load ? S_IDLE : S_LOAD;
            S_IDLE:   state_d = (bus.move == M_RESET) ? S_LOAD : (is_dir && !win_q) ? S_CHECK : S_IDLE;
            S_CHECK:  state_d = (walk || push_ok) ? S_COMMIT : S_IDLE;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_LOAD;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy       = (state_q != S_IDLE);
        bus.chunk_type = chunk_q;
        bus.win        = win_q;
        bus.steps      = steps_q;
    end

    // Datapath next state: load, commit and undo never coincide, so their writes cannot collide.
    always_comb begin
        grid_d     = grid_q;
        load_idx_d = (state_q == S_LOAD) ? load_idx_q + 1'b1 : '0;
        px_d       = px_q;
        py_d       = py_q;
        dir_d      = (state_q == S_IDLE) ? bus.move : dir_q;
        push_d     = (state_q == S_CHECK) ? push_ok : push_q;
        steps_d    = steps_q;
        recalc_d   = 1'b0;
        win_d      = recalc_q ? no_box : win_q;
        chunk_d    = (!bus.is_center || (bus.req_x >= 4'(GRID_W)) || (bus.req_y >= 4'(GRID_H))) ? C_OUTSIDE : grid_q[rd_idx];
        if (state_q == S_LOAD) begin
            grid_d[load_idx_q] = rom_cell;
            px_d               = START_X;
            py_d               = START_Y;
            steps_d            = '0;
            recalc_d           = last_load;
        end
        if (state_q == S_COMMIT) begin
            grid_d[p_idx]  = (p_c == C_PLAYER_T) ? C_TARGET : C_EMPTY;
            grid_d[n1_idx] = ((n1_c == C_TARGET) || (n1_c == C_BOX_T)) ? C_PLAYER_T : C_PLAYER;
            if (push_q) grid_d[n2_idx] = (n2_c == C_TARGET) ? C_BOX_T : C_BOX;
            px_d           = n1x[3:0];
            py_d           = n1y[3:0];
            steps_d        = (&steps_q) ? steps_q : steps_q + 10'd1;
            recalc_d       = 1'b1;
        end
`ifdef BOARD_UNDO_EN
        if (undo_fire) begin
            grid_d[idx_of(u_px_q, u_py_q)] = u_pc_q;
            grid_d[u_n1_idx_q]             = u_n1c_q;
            if (u_push_q) grid_d[u_n2_idx_q] = u_n2c_q;
            px_d                           = u_px_q;
            py_d                           = u_py_q;
            steps_d                        = (steps_q == '0) ? steps_q : steps_q - 10'd1;
            recalc_d                       = 1'b1;
        end
`endif
    end

    // The grid itself is not reset; LOAD rewrites every cell after reset.
    always_ff @(posedge clk) begin
        grid_q <= grid_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_idx_q <= '0;
            px_q       <= START_X;
            py_q       <= START_Y;
            dir_q      <= M_NONE;
            push_q     <= 1'b0;
            steps_q    <= '0;
            win_q      <= 1'b0;
            recalc_q   <= 1'b0;
            chunk_q    <= '0;
        end else begin
            load_idx_q <= load_idx_d;
            px_q       <= px_d;
            py_q       <= py_d;
            dir_q      <= dir_d;
            push_q     <= push_d;
            steps_q    <= steps_d;
            win_q      <= win_d;
            recalc_q   <= recalc_d;
            chunk_q    <= chunk_d;
        end
    end

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: directed self-checking bench for board_engine (undo checks when BOARD_UNDO_EN is defined).
module tb_board_engine;
    import board_pkg::*;

    // Level: (0,0)=TARGET (1,1)=PLAYER (3,1)=BOX (4,1)=TARGET (0,2)=BOX_T (0,3)=WALL, rest EMPTY.
    localparam logic [CELLS*CELL_W-1:0] LVL = (400'd3 << 0) | (400'd5 << 44) | (400'd2 << 52)
                                            | (400'd3 << 56) | (400'd4 << 80) | (400'd1 << 120);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    board_if bus ();

    board_engine #(.LEVEL_INIT(LVL), .START_X(4'd1), .START_Y(4'd1)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cell(input string tag, input int x, input int y, input int exp);
        bus.is_center = 1'b1;
        bus.req_x     = 4'(x);
        bus.req_y     = 4'(y);
        tick();
        check(tag, int'(bus.chunk_type), exp);
    endtask

    // Counts busy cycles, bounded so a stuck engine shows up as a wrong count.
    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    // One-cycle move pulse, wait for idle, plus one cycle so win has settled.
    task automatic do_move(input string tag, input int m, input int exp_n);
        bus.move = 3'(m);
        tick();
        bus.move = 3'd0;
        wait_idle(tag, exp_n);
        tick();
    endtask

    initial begin
        bus.is_center = 1'b1;
        bus.req_x     = 4'd0;
        bus.req_y     = 4'd0;
        bus.move      = 3'd0;
        tick();
        tick();
        check("rst_chunk", int'(bus.chunk_type), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_win", int'(bus.win), 0);
        check("rst_steps", int'(bus.steps), 0);
        rstn = 1'b1;
        wait_idle("load_cycles", 100);
        tick();
        check("load_win", int'(bus.win), 0);
        check("load_steps", int'(bus.steps), 0);
        expect_cell("load_p11", 1, 1, 5);
        expect_cell("load_b31", 3, 1, 2);
        expect_cell("load_w03", 0, 3, 1);
        bus.is_center = 1'b0;
        bus.req_x     = 4'd1;
        bus.req_y     = 4'd1;
        tick();
        check("off_center", int'(bus.chunk_type), 15);
        expect_cell("x_range", 10, 0, 15);
        expect_cell("y_range", 0, 10, 15);

        do_move("walk_r", 1, 2);
        expect_cell("walk_old", 1, 1, 0);
        expect_cell("walk_new", 2, 1, 5);
        check("walk_steps", int'(bus.steps), 1);

        do_move("push_r", 1, 2);
        expect_cell("push_p", 3, 1, 5);
        expect_cell("push_bt", 4, 1, 4);
        expect_cell("push_old", 2, 1, 0);
        check("push_win", int'(bus.win), 1);
        check("push_steps", int'(bus.steps), 2);
        do_move("won_r", 1, 0);
        check("won_steps", int'(bus.steps), 2);
        expect_cell("won_p", 3, 1, 5);

`ifdef BOARD_UNDO_EN
        do_move("undo", 6, 0);
        expect_cell("undo_p", 2, 1, 5);
        expect_cell("undo_b", 3, 1, 2);
        expect_cell("undo_t", 4, 1, 3);
        check("undo_steps", int'(bus.steps), 1);
        check("undo_win", int'(bus.win), 0);
        do_move("undo2", 6, 0);
        expect_cell("undo2_p", 2, 1, 5);
        expect_cell("undo2_b", 3, 1, 2);
        check("undo2_steps", int'(bus.steps), 1);
`else
        do_move("code6", 6, 0);
        check("code6_steps", int'(bus.steps), 2);
        expect_cell("code6_p", 3, 1, 5);
`endif

        do_move("reload", 5, 100);
        expect_cell("rl_p", 1, 1, 5);
        expect_cell("rl_e", 2, 1, 0);
        expect_cell("rl_b", 3, 1, 2);
        expect_cell("rl_t", 4, 1, 3);
        check("rl_steps", int'(bus.steps), 0);
        check("rl_win", int'(bus.win), 0);

        bus.move = 3'd1;
        tick();
        bus.move = 3'd2;
        tick();
        bus.move = 3'd0;
        wait_idle("drop_busy", 1);
        tick();
        expect_cell("drop_old", 1, 1, 0);
        expect_cell("drop_new", 2, 1, 5);
        check("drop_steps", int'(bus.steps), 1);

        do_move("left1", 2, 2);
        do_move("left2", 2, 2);
        expect_cell("left_p", 0, 1, 5);
        check("left_steps", int'(bus.steps), 3);
        do_move("left_edge", 2, 1);
        expect_cell("edge_p", 0, 1, 5);
        check("edge_steps", int'(bus.steps), 3);

        do_move("push_wall", 3, 1);
        expect_cell("pw_p", 0, 1, 5);
        expect_cell("pw_bt", 0, 2, 4);
        expect_cell("pw_w", 0, 3, 1);
        check("pw_steps", int'(bus.steps), 3);

        do_move("up_t", 4, 2);
        expect_cell("upt_p", 0, 0, 6);
        expect_cell("upt_old", 0, 1, 0);
        check("upt_steps", int'(bus.steps), 4);
        do_move("down_t", 3, 2);
        expect_cell("dnt_t", 0, 0, 3);
        expect_cell("dnt_p", 0, 1, 5);
        check("dnt_steps", int'(bus.steps), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
